// File: rtl/skew_mac4_pkg.sv
// rtl/skew_mac4_pkg.sv - shared lane geometry and FSM state type for skew_mac4
package skew_mac4_pkg;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one MAC lane: weight register, product register, accumulator
//   clk, rst_n   : clock, async active-low reset
//   w_we_i, w_i  : weight write strobe and signed weight byte
//   prod_en_i    : capture data_i * weight into the product register
//   data_i       : signed int8 lane sample
//   acc_en_i     : add sign-extended product into the accumulator
//   acc_clr_i    : zero the accumulator (wins over acc_en_i)
//   acc_o        : accumulator value
module mac_lane
  import skew_mac4_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_we_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic              prod_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              acc_en_i,
  input  logic              acc_clr_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic signed [DATA_W-1:0] w_q, w_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic [ACC_W-1:0]         acc_q, acc_d;

  always_comb begin
    w_d    = w_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    if (w_we_i) begin
      w_d = w_i;
    end
    if (prod_en_i) begin
      // Widen both operands first so the 16-bit product is fully signed.
      prod_d = PROD_W'($signed(data_i)) * PROD_W'(w_q);
    end
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      w_q    <= w_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/skew_mac4.sv
// rtl/skew_mac4.sv - four-lane int8 weight MAC with windowed accumulate and lane-serial drain
//   clk, rst_n          : clock, async active-low reset
//   data_i, valid_i     : four packed signed int8 lanes, one-cycle beat strobe
//   w_i, w_valid_i      : weight bytes, loaded lane0..lane3 after IDLE
//   clear_i             : synchronous abort to IDLE, weights kept
//   res_o, res_valid_o  : accumulator results, lane0..lane3 in order
//   res_ready_i         : downstream accept
//   in_ready_o          : beats accepted only while high
//   overflow_o          : sticky dropped-beat flag
module skew_mac4
  import skew_mac4_pkg::*;
#(
  parameter int K_LEN = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      data_i,
  input  logic             valid_i,
  input  logic [7:0]       w_i,
  input  logic             w_valid_i,
  input  logic             clear_i,
  output logic [ACC_W-1:0] res_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             in_ready_o,
  output logic             overflow_o
);

  localparam int              CNT_W  = $clog2(K_LEN + 1);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_LEN - 1);
  localparam logic [CNT_W-1:0] K_FULL = CNT_W'(K_LEN);

  state_e           state_q, state_d;
  logic [1:0]       w_idx_q, w_idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;       // products added so far
  logic [CNT_W-1:0] issued_q, issued_d; // beats captured so far
  logic             pv_q, pv_d;
  logic             ovf_q, ovf_d;

  logic [LANES-1:0] w_we;
  logic             acc_clr;
  logic             beat_acc;
  logic             res_fire;
  logic [ACC_W-1:0] acc [LANES];

  // Readiness is based on captured beats, not added ones, so the window
  // closes on the same edge the last beat enters the product stage.
  assign in_ready_o  = (state_q == ST_ACCUM) && (issued_q != K_FULL);
  assign res_valid_o = (state_q == ST_DRAIN);
  assign res_o       = res_valid_o ? acc[lane_q] : '0;
  assign overflow_o  = ovf_q;
  assign beat_acc    = valid_i && in_ready_o && !clear_i;
  assign res_fire    = res_valid_o && res_ready_i;

  always_comb begin
    state_d  = state_q;
    w_idx_d  = w_idx_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    pv_d     = beat_acc;
    ovf_d    = ovf_q;
    w_we     = '0;
    acc_clr  = 1'b0;
    if (clear_i) begin
      state_d  = ST_IDLE;
      w_idx_d  = '0;
      lane_d   = '0;
      cnt_d    = '0;
      issued_d = '0;
      ovf_d    = 1'b0;
      acc_clr  = 1'b1;
    end else begin
      if (valid_i && !in_ready_o) begin
        ovf_d = 1'b1;
      end
      if (beat_acc) begin
        issued_d = issued_q + CNT_W'(1);
      end
      if (pv_q) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (w_valid_i) begin
            w_we[0] = 1'b1;
            w_idx_d = 2'd1;
            state_d = ST_LOAD_W;
          end
        end
        ST_LOAD_W: begin
          if (w_valid_i) begin
            w_we[w_idx_q] = 1'b1;
            w_idx_d       = w_idx_q + 2'd1;
            if (w_idx_q == 2'd3) begin
              state_d  = ST_ACCUM;
              cnt_d    = '0;
              issued_d = '0;
              acc_clr  = 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          // The last add lands on this edge, so DRAIN starts with final sums.
          if (pv_q && (cnt_q == K_LAST)) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (res_fire) begin
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              state_d  = ST_ACCUM;
              cnt_d    = '0;
              issued_d = '0;
              acc_clr  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      w_idx_q  <= '0;
      lane_q   <= '0;
      cnt_q    <= '0;
      issued_q <= '0;
      pv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_idx_q  <= w_idx_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      pv_q     <= pv_d;
      ovf_q    <= ovf_d;
    end
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    mac_lane #(
      .ACC_W(ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_we_i   (w_we[n]),
      .w_i      (w_i),
      .prod_en_i(beat_acc),
      .data_i   (data_i[n*DATA_W +: DATA_W]),
      .acc_en_i (pv_q),
      .acc_clr_i(acc_clr),
      .acc_o    (acc[n])
    );
  end

endmodule

// File: tb/tb_skew_mac4.sv
// tb/tb_skew_mac4.sv - self-checking bench for skew_mac4
module tb_skew_mac4;

  localparam int K4  = 4;
  localparam int K16 = 16;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic [31:0] data_i      = '0;
  logic        valid_i     = 1'b0;
  logic [7:0]  w_i         = '0;
  logic        w_valid_i   = 1'b0;
  logic        clear_i     = 1'b0;
  logic        res_ready_i = 1'b0;
  logic [31:0] res_o;
  logic        res_valid_o, in_ready_o, overflow_o;

  logic [31:0] b_data  = '0;
  logic        b_valid = 1'b0;
  logic [7:0]  b_w     = '0;
  logic        b_wv    = 1'b0;
  logic        b_ready = 1'b0;
  logic [31:0] b_res;
  logic        b_res_valid, b_in_ready, b_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  skew_mac4 #(.K_LEN(K4), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .w_i(w_i), .w_valid_i(w_valid_i), .clear_i(clear_i),
    .res_o(res_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .in_ready_o(in_ready_o), .overflow_o(overflow_o)
  );

  skew_mac4 #(.K_LEN(K16), .ACC_W(32)) dut16 (
    .clk(clk), .rst_n(rst_n), .data_i(b_data), .valid_i(b_valid),
    .w_i(b_w), .w_valid_i(b_wv), .clear_i(1'b0),
    .res_o(b_res), .res_valid_o(b_res_valid), .res_ready_i(b_ready),
    .in_ready_o(b_in_ready), .overflow_o(b_ovf)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Transaction-level model of the K4 instance: weights, running window sums,
  // a queue of results awaiting hand-off and the cycle they become visible.
  logic signed [7:0]  m_w   [4];
  logic signed [31:0] m_sum [4];
  logic [31:0]        m_q   [$];
  int                 m_phase;   // 0 loading weights, 1 accepting beats, 2 draining
  int                 m_widx, m_beats;
  int unsigned        cyc, m_avail;
  logic               m_ovf;
  bit                 m_rdy, m_vld;

  function automatic bit m_ready();
    return (m_phase == 1) && (m_beats < K4);
  endfunction

  function automatic bit m_valid();
    return (m_q.size() != 0) && (cyc >= m_avail);
  endfunction

  task automatic m_clear(input bit keep_w);
    m_phase = 0;
    m_widx  = 0;
    m_beats = 0;
    m_ovf   = 1'b0;
    m_q.delete();
    for (int n = 0; n < 4; n++) begin
      m_sum[n] = '0;
      if (!keep_w) m_w[n] = '0;
    end
  endtask

  initial begin
    m_clear(1'b0);
    cyc     = 0;
    m_avail = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_clear(1'b0);
      end else begin
        m_rdy = m_ready();
        m_vld = m_valid();
        if (clear_i) begin
          m_clear(1'b1);
        end else begin
          if (valid_i && !m_rdy) m_ovf = 1'b1;
          if (m_vld && res_ready_i) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
              m_phase = 1;
              m_beats = 0;
              for (int n = 0; n < 4; n++) m_sum[n] = '0;
            end
          end
          if (w_valid_i && (m_phase == 0)) begin
            m_w[m_widx] = w_i;
            m_widx++;
            if (m_widx == 4) begin
              m_phase = 1;
              m_beats = 0;
            end
          end
          if (valid_i && m_rdy) begin
            for (int n = 0; n < 4; n++)
              m_sum[n] = m_sum[n] + $signed(data_i[8*n +: 8]) * m_w[n];
            m_beats++;
            if (m_beats == K4) begin
              for (int n = 0; n < 4; n++) m_q.push_back(m_sum[n]);
              // Results visible in the second cycle after the final beat's cycle.
              m_avail = cyc + 2;
              m_phase = 2;
            end
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk1("in_ready", in_ready_o, m_ready());
        chk1("res_valid", res_valid_o, m_valid());
        chk1("overflow", overflow_o, m_ovf);
        if (m_valid()) chk32("res_o", res_o, m_q[0]);
      end
    end
  end

  // Accepted results: sample outputs on the falling edge, commit on the rising edge.
  logic [31:0] got [$];
  logic [31:0] bgot [$];
  logic        l_v = 1'b0, lb_v = 1'b0;
  logic [31:0] l_r = '0, lb_r = '0;

  initial begin
    forever begin
      @(negedge clk);
      l_v  = rst_n && res_valid_o;
      l_r  = res_o;
      lb_v = rst_n && b_res_valid;
      lb_r = b_res;
      @(posedge clk);
      if (rst_n && l_v && res_ready_i) got.push_back(l_r);
      if (rst_n && lb_v && b_ready) bgot.push_back(lb_r);
    end
  end

  task automatic send_w(input logic [7:0] w);
    w_i = w;
    w_valid_i = 1'b1;
    @(negedge clk);
    w_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d);
    data_i = d;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_n(input int which, input int n);
    for (int i = 0; i < 80; i++) begin
      if (((which == 0) ? got.size() : bgot.size()) >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic chk_win(input string name, input logic [31:0] q [$],
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    chk32({name, "_count"}, 32'(q.size()), 32'd4);
    if (q.size() == 4) begin
      chk32({name, "_lane0"}, q[0], e0);
      chk32({name, "_lane1"}, q[1], e1);
      chk32({name, "_lane2"}, q[2], e2);
      chk32({name, "_lane3"}, q[3], e3);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk32("rst_res_o", res_o, 32'd0);
    chk1("rst_res_valid", res_valid_o, 1'b0);
    chk1("rst_in_ready", in_ready_o, 1'b0);
    chk1("rst_overflow", overflow_o, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Window of ones against weights 1..4, downstream always ready.
    res_ready_i = 1'b1;
    send_w(8'd1); send_w(8'd2); send_w(8'd3);
    chk1("ready_before_w3", in_ready_o, 1'b0);
    send_w(8'd4);
    chk1("ready_after_weights", in_ready_o, 1'b1);
    got.delete();
    repeat (3) send_beat(32'h01010101);
    chk1("ready_before_last", in_ready_o, 1'b1);
    send_beat(32'h01010101);
    chk1("ready_drop_last", in_ready_o, 1'b0);
    chk1("lat_early", res_valid_o, 1'b0);
    @(negedge clk);
    chk1("lat_first", res_valid_o, 1'b1);
    chk32("lat_first_val", res_o, 32'd4);
    repeat (4) @(negedge clk);
    chk32("win1_consecutive", 32'(got.size()), 32'd4);
    chk1("win1_back_to_accum", in_ready_o, 1'b1);
    chk_win("win1", got, 32'd4, 32'd8, 32'd12, 32'd16);

    // Mixed-sign lanes with downstream stalled for five cycles.
    res_ready_i = 1'b0;
    got.delete();
    send_w(8'h55);
    repeat (4) send_beat(32'hFF02FD05);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk1("stall_valid", res_valid_o, 1'b1);
      chk32("stall_hold", res_o, 32'd20);
      @(negedge clk);
    end
    res_ready_i = 1'b1;
    wait_n(0, 4);
    chk_win("win_stall", got, 32'd20, 32'hFFFF_FFE8, 32'd24, 32'hFFFF_FFF0);

    // Beat dropped during DRAIN: sticky flag, later window unaffected.
    res_ready_i = 1'b0;
    got.delete();
    repeat (4) send_beat(32'h01010101);
    @(negedge clk);
    send_beat(32'h7F7F7F7F);
    chk1("ovf_set", overflow_o, 1'b1);
    res_ready_i = 1'b1;
    wait_n(0, 4);
    chk_win("win_ovf", got, 32'd4, 32'd8, 32'd12, 32'd16);
    got.delete();
    @(negedge clk);
    repeat (4) send_beat(32'h02020202);
    wait_n(0, 4);
    chk_win("win_after_drop", got, 32'd8, 32'd16, 32'd24, 32'd32);
    chk1("ovf_sticky", overflow_o, 1'b1);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk1("ovf_cleared", overflow_o, 1'b0);
    chk1("clear_idle", in_ready_o, 1'b0);

    // Abort mid-window, then a full reload is needed before beats count again.
    got.delete();
    repeat (4) send_w(8'd2);
    chk1("reload_ready", in_ready_o, 1'b1);
    repeat (2) send_beat(32'h05050505);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk1("abort_idle", in_ready_o, 1'b0);
    w_i = 8'h7F;
    w_valid_i = 1'b1;
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    w_valid_i = 1'b0;
    send_w(8'hFF); send_w(8'h01); send_w(8'hFF);
    chk1("three_writes_not_ready", in_ready_o, 1'b0);
    send_w(8'h01);
    chk1("four_writes_ready", in_ready_o, 1'b1);
    repeat (4) send_beat(32'h03030303);
    wait_n(0, 4);
    chk_win("win_abort", got, 32'hFFFF_FFF4, 32'd12, 32'hFFFF_FFF4, 32'd12);

    // Asynchronous reset in the middle of DRAIN.
    res_ready_i = 1'b0;
    got.delete();
    repeat (4) send_beat(32'h01010101);
    repeat (2) @(negedge clk);
    send_beat(32'h01010101);
    chk1("pre_rst_ovf", overflow_o, 1'b1);
    chk1("pre_rst_valid", res_valid_o, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk32("arst_res_o", res_o, 32'd0);
    chk1("arst_res_valid", res_valid_o, 1'b0);
    chk1("arst_in_ready", in_ready_o, 1'b0);
    chk1("arst_overflow", overflow_o, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_idle", in_ready_o, 1'b0);
    chk1("post_rst_no_res", res_valid_o, 1'b0);

    // K_LEN=16 instance at the most negative operands.
    b_ready = 1'b1;
    bgot.delete();
    for (int i = 0; i < 4; i++) begin
      b_w = 8'h80;
      b_wv = 1'b1;
      @(negedge clk);
      b_wv = 1'b0;
    end
    chk1("k16_ready", b_in_ready, 1'b1);
    for (int i = 0; i < K16; i++) begin
      if (i == K16 - 1) chk1("k16_ready_before_last", b_in_ready, 1'b1);
      b_data = 32'h80808080;
      b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
    end
    chk1("k16_ready_drop", b_in_ready, 1'b0);
    wait_n(1, 4);
    chk_win("k16", bgot, 32'd262144, 32'd262144, 32'd262144, 32'd262144);
    chk1("k16_no_ovf", b_ovf, 1'b0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
